shift_arbiter: RTL

Shares one `shift_unit32` datapath between `NREQ` issue lanes. Each cycle it grants at most one lane's shift request (SLL/SRL/SRA, ctrl 4'b0101/0110/0111) and latches its operands into a one-entry result stage. It then presents the shifted result, lane id and tag on a single valid/ready response port. It sits between the issue lanes and writeback, and holds its result under backpressure.

---
 rtl/shift_pkg.sv | 22 ++
 rtl/shift_unit32.sv | 23 ++
 rtl/shift_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice: ALU control codes,
// datapath widths, the result-stage state encoding and a ctrl decode helper.
package shift_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic [3:0] CTRL_SLL = 4'b0101;
    localparam logic [3:0] CTRL_SRL = 4'b0110;
    localparam logic [3:0] CTRL_SRA = 4'b0111;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // True when ctrl selects one of the three supported shifts.
    function automatic logic is_shift_ctrl(input logic [3:0] ctrl);
        return (ctrl == CTRL_SLL) || (ctrl == CTRL_SRL) || (ctrl == CTRL_SRA);
    endfunction

endpackage

// File: rtl/shift_unit32.sv
// 32-bit barrel shifter: SLL / SRL / SRA selected by the ALU ctrl code.
// Any non-shift ctrl yields zero.
module shift_unit32
    import shift_pkg::*;
(
    input  logic [XLEN-1:0]    rs1,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [3:0]         ctrl,
    output logic [XLEN-1:0]    result
);

    // Select the shift direction/fill from the control code.
    always_comb begin
        result = {XLEN{1'b0}};
        case (ctrl)
            CTRL_SLL: result = rs1 << shamt;
            CTRL_SRL: result = rs1 >> shamt;
            CTRL_SRA: result = XLEN'($signed(rs1) >>> shamt);
            default:  result = {XLEN{1'b0}};
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one shift_unit32 between NREQ issue lanes through a
// one-entry result stage with a valid/ready response port.
// Build option: define SHIFT_ARB_RR_EN for round-robin arbitration; without
// it the lowest-index valid lane always wins and no grant history is kept.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int NREQ  = 2,
    parameter int TAG_W = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ*32-1:0]        req_rs1,
    input  logic [NREQ*32-1:0]        req_rs2,
    input  logic [NREQ*4-1:0]         req_ctrl,
    input  logic [NREQ*TAG_W-1:0]     req_tag,
    input  logic                      flush,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [31:0]               resp_data,
    output logic [$clog2(NREQ)-1:0]   resp_id,
    output logic [TAG_W-1:0]          resp_tag,
    output logic                      resp_illegal
);

    localparam int ID_W = $clog2(NREQ);

    stage_state_e        state_r;
    stage_state_e        state_nxt_s;
    logic [XLEN-1:0]     rs1_r;
    logic [SHAMT_W-1:0]  sh_r;
    logic [3:0]          ctrl_r;
    logic [TAG_W-1:0]    tag_r;
    logic [ID_W-1:0]     id_r;

    logic                grant_valid_s;
    logic [ID_W-1:0]     grant_id_s;
    logic                stage_free_s;
    logic                accept_s;

    // Only the low five bits of each rs2 slice carry a shift amount.
    logic                unused_rs2_s;
    assign unused_rs2_s = ^req_rs2;

    // Stage can take a new request when it is empty or draining this cycle,
    // and a flush always blocks acceptance. Reset holds every lane off.
    assign stage_free_s = ((state_r == ST_EMPTY) || resp_ready) && !flush;
    assign accept_s     = rst_n && grant_valid_s && stage_free_s;

`ifdef SHIFT_ARB_RR_EN
    logic [ID_W-1:0] last_grant_r;

    // Round-robin search starting one past the most recently accepted lane.
    always_comb begin
        int idx_v;
        grant_valid_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        idx_v         = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx_v = int'(last_grant_r) + k;
            if (idx_v >= NREQ) begin
                idx_v = idx_v - NREQ;
            end else begin
                idx_v = idx_v;
            end
            if (!grant_valid_s && req_valid[idx_v]) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ID_W'(idx_v);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Grant history advances only on an accepted transfer; NREQ-1 after
    // reset so lane 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= ID_W'(NREQ - 1);
        end else if (accept_s) begin
            last_grant_r <= grant_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end
`else
    // Fixed priority: scan from the top so the lowest valid index wins last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = {ID_W{1'b0}};
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_valid_s = 1'b1;
                grant_id_s    = ID_W'(i);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end
`endif

    // Ready goes to the granted lane only, and only when the stage accepts.
    always_comb begin
        req_ready = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = accept_s && (grant_id_s == ID_W'(i));
        end
    end

    // Result-stage next state: flush wins, then refill, then drain.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (flush) begin
                    state_nxt_s = ST_EMPTY;
                end else if (accept_s) begin
                    state_nxt_s = ST_FULL;
                end else if (resp_ready) begin
                    state_nxt_s = ST_EMPTY;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: state_nxt_s = ST_EMPTY;
        endcase
    end

    // Result-stage state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the granted lane's operands; held unchanged under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_r  <= {XLEN{1'b0}};
            sh_r   <= {SHAMT_W{1'b0}};
            ctrl_r <= 4'b0000;
            tag_r  <= {TAG_W{1'b0}};
            id_r   <= {ID_W{1'b0}};
        end else if (accept_s) begin
            rs1_r  <= req_rs1[32*grant_id_s +: 32];
            sh_r   <= req_rs2[32*grant_id_s +: SHAMT_W];
            ctrl_r <= req_ctrl[4*grant_id_s +: 4];
            tag_r  <= req_tag[TAG_W*grant_id_s +: TAG_W];
            id_r   <= grant_id_s;
        end else begin
            rs1_r  <= rs1_r;
            sh_r   <= sh_r;
            ctrl_r <= ctrl_r;
            tag_r  <= tag_r;
            id_r   <= id_r;
        end
    end

    shift_unit32 u_shift (
        .rs1    (rs1_r),
        .shamt  (sh_r),
        .ctrl   (ctrl_r),
        .result (resp_data)
    );

    assign resp_valid   = (state_r == ST_FULL);
    assign resp_id      = id_r;
    assign resp_tag     = tag_r;
    assign resp_illegal = resp_valid && !is_shift_ctrl(ctrl_r);

endmodule
